banked_mem_responder: RTL

- Memory-side responder for the cache controller's memory request interface. The controller drives addr/data_in/wr/rd; this block returns data_out, stall, busy and err.
- Four interleaved word-addressed banks, each with a fixed multi-cycle occupancy, so the controller can pipeline accesses to distinct banks.
- Sits between the cache controller and the backing storage. Also serves as the standalone memory model in the cache testbench.

---
 rtl/cache_mem_pkg.sv | 30 +++
 rtl/mem_bank.sv | 79 +++++++
 rtl/banked_mem_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// -----------------------------------------------------------------------------
// cache_mem_pkg
// Shared definitions for the cache controller's memory request interface and
// the banked memory responder behind it.
//   - bank geometry (bank count, bank-select field position and width)
//   - default per-access bank occupancy
//   - request-kind encoding of {wr, rd}, shared with the cache controller
// -----------------------------------------------------------------------------
package cache_mem_pkg;

    localparam int N_BANKS          = 4;
    localparam int BANK_SEL_LSB     = 1;
    localparam int BANK_SEL_W       = 2;
    localparam int BUSY_CYCLES_DEF  = 4;
    localparam int DATA_W           = 16;

    // Request kind as seen on {wr, rd}.
    typedef enum logic [1:0] {
        REQ_NONE    = 2'b00,
        REQ_READ    = 2'b01,
        REQ_WRITE   = 2'b10,
        REQ_ILLEGAL = 2'b11
    } req_kind_e;

    // Classify a request from its write/read strobes.
    function automatic req_kind_e req_kind(input logic wr, input logic rd);
        return req_kind_e'({wr, rd});
    endfunction

endpackage : cache_mem_pkg

// File: rtl/mem_bank.sv
// -----------------------------------------------------------------------------
// mem_bank
// One interleaved word bank: storage array, occupancy countdown and the
// write/read ports. The top level decides acceptance; this block only acts on
// the accept strobe it is given.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (clears occupancy, not storage)
//   i_acc      access accepted for this bank this cycle
//   i_we       accepted access is a write
//   i_row      row addressed by the accepted access
//   i_wdata    write data
//   i_rd_row   row to read; read word appears on o_rdata next cycle
//   o_rdata    registered read word
//   o_busy     registered occupancy flag (counter nonzero)
// -----------------------------------------------------------------------------
module mem_bank
    import cache_mem_pkg::*;
#(
    parameter int ROW_W       = 13,
    parameter int BANK_WORDS  = 8192,
    parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_acc,
    input  logic              i_we,
    input  logic [ROW_W-1:0]  i_row,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ROW_W-1:0]  i_rd_row,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(BUSY_CYCLES);

    logic [DATA_W-1:0] r_mem [BANK_WORDS];
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Next occupancy count: load on accept, otherwise count down to zero.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_acc) begin
            w_cnt_nxt = CNT_W'(BUSY_CYCLES - 1);
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Occupancy counter and its registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= {CNT_W{1'b0}};
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != {CNT_W{1'b0}});
        end
    end

    // Storage write port and synchronous read port; contents survive reset.
    // A same-row write/read collision cannot occur: the bank is busy for at
    // least one cycle after any accepted access.
    always_ff @(posedge clk) begin
        if (i_acc && i_we) begin
            r_mem[i_row] <= i_wdata;
        end
        r_rdata <= r_mem[i_rd_row];
    end

    assign o_rdata = r_rdata;
    assign o_busy  = r_busy;

endmodule : mem_bank

// File: rtl/banked_mem_responder.sv
// -----------------------------------------------------------------------------
// banked_mem_responder
// Memory-side responder for the cache controller. Four word-interleaved banks,
// each occupied for BUSY_CYCLES per accepted access; reads return exactly two
// cycles after acceptance, in accept order.
// Ports:
//   clk       clock
//   rst       synchronous active-high reset
//   addr      byte address (bank = addr[2:1], row = addr[ADDR_W-1:3])
//   data_in   write data
//   wr, rd    request strobes (both high = illegal)
//   data_out  read data in the return cycle, 0 otherwise
//   stall     legal request dropped because its bank is busy (combinational)
//   busy      per-bank occupancy (registered)
//   err       illegal request this cycle (combinational)
// -----------------------------------------------------------------------------
module banked_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int BANK_WORDS  = 8192,
    parameter int BUSY_CYCLES = BUSY_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic [N_BANKS-1:0] busy,
    output logic              err
);

    localparam int ROW_W = ADDR_W - 3;

    req_kind_e             w_kind;
    logic                  w_req;
    logic                  w_illegal;
    logic [BANK_SEL_W-1:0] w_bank;
    logic [ROW_W-1:0]      w_row;
    logic                  w_accept;
    logic                  w_is_write;
    logic [N_BANKS-1:0]    w_busy;
    logic [N_BANKS-1:0]    w_acc_vec;
    logic [DATA_W-1:0]     w_rdata [N_BANKS];

    // Return pipeline: stage 1 addresses the bank read port, stage 2 selects it.
    logic                  r_v1;
    logic [BANK_SEL_W-1:0] r_bank1;
    logic [ROW_W-1:0]      r_row1;
    logic                  r_v2;
    logic [BANK_SEL_W-1:0] r_bank2;

    assign w_bank = addr[BANK_SEL_LSB +: BANK_SEL_W];
    assign w_row  = addr[ADDR_W-1:3];

    // Request decode, legality and acceptance; stall/err are masked in reset.
    always_comb begin
        w_kind     = req_kind(wr, rd);
        w_req      = (w_kind != REQ_NONE);
        w_illegal  = (w_kind == REQ_ILLEGAL) || (w_req && addr[0]);
        w_is_write = (w_kind == REQ_WRITE);
        w_accept   = 1'b0;
        stall      = 1'b0;
        err        = 1'b0;
        if (rst) begin
            w_accept = 1'b0;
            stall    = 1'b0;
            err      = 1'b0;
        end else begin
            err      = w_illegal;
            stall    = w_req && !w_illegal && w_busy[w_bank];
            w_accept = w_req && !w_illegal && !w_busy[w_bank];
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_BANKS; g++) begin : g_bank
            assign w_acc_vec[g] = w_accept && (w_bank == BANK_SEL_W'(g));

            mem_bank #(
                .ROW_W       (ROW_W),
                .BANK_WORDS  (BANK_WORDS),
                .BUSY_CYCLES (BUSY_CYCLES)
            ) u_bank (
                .clk      (clk),
                .rst      (rst),
                .i_acc    (w_acc_vec[g]),
                .i_we     (w_is_write),
                .i_row    (w_row),
                .i_wdata  (data_in),
                .i_rd_row (r_row1),
                .o_rdata  (w_rdata[g]),
                .o_busy   (w_busy[g])
            );
        end
    endgenerate

    // Read return pipeline; reset discards reads in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_bank1 <= {BANK_SEL_W{1'b0}};
            r_row1  <= {ROW_W{1'b0}};
            r_v2    <= 1'b0;
            r_bank2 <= {BANK_SEL_W{1'b0}};
        end else begin
            r_v1    <= w_accept && (w_kind == REQ_READ);
            r_bank1 <= w_bank;
            r_row1  <= w_row;
            r_v2    <= r_v1;
            r_bank2 <= r_bank1;
        end
    end

    // Output mux: only the returning bank's registered word, else zero.
    always_comb begin
        data_out = {DATA_W{1'b0}};
        if (r_v2) begin
            data_out = w_rdata[r_bank2];
        end else begin
            data_out = {DATA_W{1'b0}};
        end
    end

    assign busy = w_busy;

endmodule : banked_mem_responder
